// File: rtl/mc_cpu.sv
// mc_cpu: multi-cycle MIPS-subset core over one shared req/ready memory port.
// Ports: clk/rst, mem_* bus, dbg_reg_sel/dbg_reg_data tap, test_inst, retired, halted.
module mc_cpu #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  input  logic [4:0]        dbg_reg_sel,
  output logic [31:0]       dbg_reg_data,
  output logic [31:0]       test_inst,
  output logic [CNT_W-1:0]  retired,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] pc;
  logic [31:0] ir, a, b, alu_out, mdr;
  logic [31:0] regs [32];

  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm, pc32, alu_res;
  logic is_r, r_ok, is_addi, is_lw, is_sw;
  logic is_beq, is_bne, is_j, is_br, legal, taken;
  logic [ADDR_W-1:0] br_tgt, j_tgt;
  logic [4:0]  wr_idx;
  logic [31:0] wr_val;
  logic retire;

  assign op  = ir[31:26];
  assign fn  = ir[5:0];
  assign rs  = ir[25:21];
  assign rt  = ir[20:16];
  assign rd  = ir[15:11];
  assign imm = {{16{ir[15]}}, ir[15:0]};

  assign is_r    = op == 6'h00;
  assign r_ok    = is_r & (fn == 6'h20 | fn == 6'h22 |
                   fn == 6'h24 | fn == 6'h25 | fn == 6'h2A);
  assign is_addi = op == 6'h08;
  assign is_lw   = op == 6'h23;
  assign is_sw   = op == 6'h2B;
  assign is_beq  = op == 6'h04;
  assign is_bne  = op == 6'h05;
  assign is_j    = op == 6'h02;
  assign is_br   = is_beq | is_bne | is_j;
  assign legal   = r_ok | is_addi | is_lw | is_sw | is_br;
  assign taken   = is_j | (is_beq & (a == b)) | (is_bne & (a != b));

  // pc already holds PC+4 once the fetch has completed
  assign pc32   = 32'(pc);
  assign br_tgt = ADDR_W'(pc32 + (imm << 2));
  assign j_tgt  = ADDR_W'({pc32[31:28], ir[25:0], 2'b00});

  always_comb begin
    alu_res = a + imm;
    if (is_r) begin
      unique case (fn)
        6'h22:   alu_res = a - b;
        6'h24:   alu_res = a & b;
        6'h25:   alu_res = a | b;
        6'h2A:   alu_res = {31'b0, $signed(a) < $signed(b)};
        default: alu_res = a + b;
      endcase
    end
  end

  assign wr_idx = is_r ? rd : rt;
  assign wr_val = is_lw ? mdr : alu_out;

  assign retire = (state == S_EXEC & legal & is_br) |
                  (state == S_MEM & mem_ready & is_sw) |
                  (state == S_WB);

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_FETCH:  if (mem_ready) state_nx = S_DECODE;
      S_DECODE: state_nx = S_EXEC;
      S_EXEC: begin
        unique case (1'b1)
          !legal:         state_nx = S_HALT;
          is_br:          state_nx = S_FETCH;
          is_lw | is_sw:  state_nx = S_MEM;
          default:        state_nx = S_WB;
        endcase
      end
      S_MEM:    if (mem_ready) state_nx = is_sw ? S_FETCH : S_WB;
      S_WB:     state_nx = S_FETCH;
      default:  state_nx = S_HALT;
    endcase
  end

  // rst gates the bus so a pending store is never committed
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pc;
    mem_wdata = 32'h0;
    if (rst) begin
      mem_addr = RESET_PC;
    end else if (state == S_FETCH) begin
      mem_req = 1'b1;
    end else if (state == S_MEM) begin
      mem_req   = 1'b1;
      mem_we    = is_sw;
      mem_addr  = ADDR_W'(alu_out);
      mem_wdata = b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      mdr     <= '0;
      retired <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      unique case (state)
        S_FETCH: if (mem_ready) begin
          ir <= mem_rdata;
          pc <= pc + ADDR_W'(4);
        end
        S_DECODE: begin
          a <= regs[rs];
          b <= regs[rt];
        end
        S_EXEC: begin
          alu_out <= alu_res;
          if (legal & taken) pc <= is_j ? j_tgt : br_tgt;
        end
        S_MEM: if (mem_ready & is_lw) mdr <= mem_rdata;
        S_WB: if (wr_idx != 5'd0) regs[wr_idx] <= wr_val;
        default: ;
      endcase
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  assign dbg_reg_data = regs[dbg_reg_sel];
  assign test_inst    = ir;
  assign halted       = state == S_HALT;

endmodule
